// File: rtl/rvdff_share_pkg.sv
// Shared types and helpers for the rvdff_share_arb holding-register arbiter.
package rvdff_share_pkg;

   localparam int NREQ_MAX = 8;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } buf_state_e;

   // Index width for n entries, never less than one bit.
   function automatic int idx_width(input int n);
      int w;
      w = 1;
      while ((1 << w) < n) w++;
      return w;
   endfunction

endpackage

// File: rtl/rvdff_share_arb_rr_pick.sv
// Combinational round-robin picker: first valid entry at or above ptr, wrapping to 0.
module rr_pick #(
   parameter int NREQ = 4,
   parameter int IDXW = 2
) (
   input  logic [NREQ-1:0] valid,
   input  logic [IDXW-1:0] ptr,
   input  logic            en,
   output logic [NREQ-1:0] grant,
   output logic [IDXW-1:0] idx,
   output logic            found
);

   logic [IDXW:0] cand;

   // One extra bit on cand so ptr+k can exceed NREQ before the wrap subtract.
   always_comb begin
      grant = '0;
      idx   = '0;
      found = 1'b0;
      cand  = '0;
      for (int k = 0; k < NREQ; k++) begin
         cand = {1'b0, ptr} + (IDXW+1)'(k);
         if (cand >= (IDXW+1)'(NREQ)) begin
            cand = cand - (IDXW+1)'(NREQ);
         end
         if (en && !found && valid[cand[IDXW-1:0]]) begin
            grant[cand[IDXW-1:0]] = 1'b1;
            idx                   = cand[IDXW-1:0];
            found                 = 1'b1;
         end
      end
   end

endmodule

// File: rtl/rvdff_share_arb.sv
// Round-robin arbiter sharing one flop holding register among NREQ valid/ready producers.
// Optional grant locking is enabled with `define RVDFF_SHARE_ARB_LOCK_EN.
module rvdff_share_arb
   import rvdff_share_pkg::*;
#(
   parameter int NREQ  = 4,
   parameter int WIDTH = 16
) (
   input  logic                        clk,
   input  logic                        rst_l,
   input  logic [NREQ-1:0]             req_valid,
   input  logic [NREQ*WIDTH-1:0]       req_data,
   output logic [NREQ-1:0]             req_ready,
   output logic                        out_valid,
   output logic [WIDTH-1:0]            out_data,
   output logic [idx_width(NREQ)-1:0]  out_src,
   input  logic                        out_ready,
   output logic [idx_width(NREQ)-1:0]  rr_ptr_o
`ifdef RVDFF_SHARE_ARB_LOCK_EN
   ,
   input  logic [NREQ-1:0]             req_lock
`endif
);

   localparam int IDXW = idx_width(NREQ);

   if (NREQ < 2 || NREQ > NREQ_MAX) begin : g_bad_nreq
      $error("rvdff_share_arb: NREQ out of range");
   end

   buf_state_e       state_q, state_d;
   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic [IDXW-1:0]  out_src_q, out_src_d;
   logic [IDXW-1:0]  rr_ptr_q, rr_ptr_d;

   logic             can_accept;
   logic             pick_en;
   logic [NREQ-1:0]  arb_valid;
   logic [NREQ-1:0]  grant;
   logic [IDXW-1:0]  win_idx;
   logic             xfer;
   logic [IDXW-1:0]  win_next;
   logic [WIDTH-1:0] req_data_a [NREQ];

   for (genvar g = 0; g < NREQ; g++) begin : g_unpack
      assign req_data_a[g] = req_data[g*WIDTH +: WIDTH];
   end

   // Gating with rst_l keeps req_ready low for the whole time reset is held.
   assign can_accept = (state_q == EMPTY) || out_ready;
   assign pick_en    = can_accept && rst_l;
   assign win_next   = (win_idx == IDXW'(NREQ-1)) ? '0 : win_idx + IDXW'(1);

`ifdef RVDFF_SHARE_ARB_LOCK_EN
   logic            lock_q, lock_d;
   logic [IDXW-1:0] lock_idx_q, lock_idx_d;

   assign arb_valid = lock_q ? (req_valid & (NREQ'(1) << lock_idx_q)) : req_valid;
`else
   assign arb_valid = req_valid;
`endif

   rr_pick #(
      .NREQ (NREQ),
      .IDXW (IDXW)
   ) u_rr_pick (
      .valid (arb_valid),
      .ptr   (rr_ptr_q),
      .en    (pick_en),
      .grant (grant),
      .idx   (win_idx),
      .found (xfer)
   );

   assign req_ready = grant;
   assign out_valid = (state_q == FULL);
   assign out_data  = out_data_q;
   assign out_src   = out_src_q;
   assign rr_ptr_o  = rr_ptr_q;

   // A transfer always wins over a drain, so back-to-back beats keep the buffer FULL.
   always_comb begin
      state_d    = state_q;
      out_data_d = out_data_q;
      out_src_d  = out_src_q;
      rr_ptr_d   = rr_ptr_q;
      if (xfer) begin
         state_d    = FULL;
         out_data_d = req_data_a[win_idx];
         out_src_d  = win_idx;
         rr_ptr_d   = win_next;
      end else if ((state_q == FULL) && out_ready) begin
         state_d = EMPTY;
      end
`ifdef RVDFF_SHARE_ARB_LOCK_EN
      if (xfer && req_lock[win_idx]) begin
         rr_ptr_d = rr_ptr_q;
      end
`endif
   end

`ifdef RVDFF_SHARE_ARB_LOCK_EN
   // A lock holder that withdraws while we could accept gives up the lock without a beat.
   always_comb begin
      lock_d     = lock_q;
      lock_idx_d = lock_idx_q;
      if (xfer) begin
         lock_d     = req_lock[win_idx];
         lock_idx_d = win_idx;
      end else if (lock_q && can_accept && !req_valid[lock_idx_q]) begin
         lock_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         lock_q     <= 1'b0;
         lock_idx_q <= '0;
      end else begin
         lock_q     <= lock_d;
         lock_idx_q <= lock_idx_d;
      end
   end
`endif

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         state_q  <= EMPTY;
         rr_ptr_q <= '0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
      end
   end

   // Holding register: enabled flop, only written on a transfer.
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         out_data_q <= '0;
         out_src_q  <= '0;
      end else if (xfer) begin
         out_data_q <= out_data_d;
         out_src_q  <= out_src_d;
      end
   end

endmodule

// File: tb/tb_rvdff_share_arb.sv
// Directed bench for rvdff_share_arb in its default build (NREQ=4, WIDTH=16, no lock).
module tb_rvdff_share_arb;

   logic        clk;
   logic        rst_l;
   logic [3:0]  req_valid;
   logic [63:0] req_data;
   logic [3:0]  req_ready;
   logic        out_valid;
   logic [15:0] out_data;
   logic [1:0]  out_src;
   logic        out_ready;
   logic [1:0]  rr_ptr_o;

   int checks;
   int errors;

   typedef struct {
      logic [3:0]  valid;
      logic [63:0] data;
      logic        oready;
      logic [3:0]  exp_ready;
      logic        exp_valid;
      logic [15:0] exp_data;
      logic [1:0]  exp_src;
      logic [1:0]  exp_ptr;
   } vec_t;

   vec_t vecs[$];

   localparam logic [63:0] ALL_DATA = {16'h0013, 16'h0012, 16'h0011, 16'h0010};
   localparam logic [63:0] BEEF_2   = {16'h0003, 16'hBEEF, 16'h0001, 16'h0000};
   localparam logic [63:0] D1234_0  = {16'h0003, 16'h0002, 16'h0001, 16'h1234};
   localparam logic [63:0] BP_DATA  = {16'hCCCC, 16'h0002, 16'hAAAA, 16'h1234};
   localparam logic [63:0] D5555_0  = {16'h0003, 16'h0002, 16'h0001, 16'h5555};

   rvdff_share_arb #(
      .NREQ  (4),
      .WIDTH (16)
   ) dut (
      .clk       (clk),
      .rst_l     (rst_l),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_ready (req_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_src   (out_src),
      .out_ready (out_ready),
      .rr_ptr_o  (rr_ptr_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic applyStimulus(input logic [3:0] valid, input logic [63:0] data, input logic oready);
      req_valid = valid;
      req_data  = data;
      out_ready = oready;
   endtask

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s got %0h expected %0h", name, actual, expected);
      end
   endtask

   function automatic void addVec(input logic [3:0] valid, input logic [63:0] data, input logic oready,
                                  input logic [3:0] exp_ready, input logic exp_valid,
                                  input logic [15:0] exp_data, input logic [1:0] exp_src,
                                  input logic [1:0] exp_ptr);
      vec_t v;
      v.valid     = valid;
      v.data      = data;
      v.oready    = oready;
      v.exp_ready = exp_ready;
      v.exp_valid = exp_valid;
      v.exp_data  = exp_data;
      v.exp_src   = exp_src;
      v.exp_ptr   = exp_ptr;
      vecs.push_back(v);
   endfunction

   initial begin
      checks = 0;
      errors = 0;

      // First grant after reset, then a lone writer at requester 2, then drain and idle.
      addVec(4'b1111, ALL_DATA, 1'b1, 4'b0001, 1'b1, 16'h0010, 2'd0, 2'd1);
      addVec(4'b0100, BEEF_2,   1'b1, 4'b0100, 1'b1, 16'hBEEF, 2'd2, 2'd3);
      addVec(4'b0000, BEEF_2,   1'b1, 4'b0000, 1'b0, 16'hBEEF, 2'd2, 2'd3);
      addVec(4'b0000, BEEF_2,   1'b0, 4'b0000, 1'b0, 16'hBEEF, 2'd2, 2'd3);
      // All requesters valid: pointer at 3 first, then two full 0..3 rotations.
      addVec(4'b1111, ALL_DATA, 1'b1, 4'b1000, 1'b1, 16'h0013, 2'd3, 2'd0);
      for (int r = 0; r < 2; r++) begin
         for (int i = 0; i < 4; i++) begin
            addVec(4'b1111, ALL_DATA, 1'b1, 4'b0001 << i, 1'b1, 16'h0010 + 16'(i), 2'(i), 2'((i + 1) % 4));
         end
      end
      // Load 1234 from requester 0 while FULL and draining, leaving the pointer at 1.
      addVec(4'b0001, D1234_0, 1'b1, 4'b0001, 1'b1, 16'h1234, 2'd0, 2'd1);
      for (int i = 0; i < 5; i++) begin
         addVec(4'b1010, BP_DATA, 1'b0, 4'b0000, 1'b1, 16'h1234, 2'd0, 2'd1);
      end
      addVec(4'b1010, BP_DATA, 1'b1, 4'b0010, 1'b1, 16'hAAAA, 2'd1, 2'd2);
      addVec(4'b1010, BP_DATA, 1'b1, 4'b1000, 1'b1, 16'hCCCC, 2'd3, 2'd0);
      addVec(4'b1010, BP_DATA, 1'b1, 4'b0010, 1'b1, 16'hAAAA, 2'd1, 2'd2);
      addVec(4'b0000, BP_DATA, 1'b1, 4'b0000, 1'b0, 16'hAAAA, 2'd1, 2'd2);

      rst_l = 1'b0;
      applyStimulus(4'b1111, ALL_DATA, 1'b1);
      repeat (2) @(negedge clk);
      checkOutput("reset req_ready", 64'(req_ready), 64'h0);
      checkOutput("reset out_valid", 64'(out_valid), 64'h0);
      checkOutput("reset out_data",  64'(out_data),  64'h0);
      checkOutput("reset out_src",   64'(out_src),   64'h0);
      checkOutput("reset rr_ptr",    64'(rr_ptr_o),  64'h0);
      rst_l = 1'b1;

      foreach (vecs[i]) begin
         applyStimulus(vecs[i].valid, vecs[i].data, vecs[i].oready);
         #1;
         checkOutput($sformatf("v%0d req_ready", i), 64'(req_ready), 64'(vecs[i].exp_ready));
         @(posedge clk);
         #1;
         checkOutput($sformatf("v%0d out_valid", i), 64'(out_valid), 64'(vecs[i].exp_valid));
         checkOutput($sformatf("v%0d out_data", i),  64'(out_data),  64'(vecs[i].exp_data));
         checkOutput($sformatf("v%0d out_src", i),   64'(out_src),   64'(vecs[i].exp_src));
         checkOutput($sformatf("v%0d rr_ptr", i),    64'(rr_ptr_o),  64'(vecs[i].exp_ptr));
         @(negedge clk);
      end

      // Async reset while FULL and stalled: out_valid must drop before the next edge.
      applyStimulus(4'b0001, D5555_0, 1'b0);
      @(posedge clk);
      #1;
      checkOutput("pre-reset out_valid", 64'(out_valid), 64'h1);
      checkOutput("pre-reset out_data",  64'(out_data),  64'h5555);
      checkOutput("pre-reset rr_ptr",    64'(rr_ptr_o),  64'h1);
      @(negedge clk);
      #2;
      rst_l = 1'b0;
      #1;
      checkOutput("async out_valid", 64'(out_valid), 64'h0);
      checkOutput("async out_data",  64'(out_data),  64'h0);
      checkOutput("async rr_ptr",    64'(rr_ptr_o),  64'h0);
      checkOutput("async req_ready", 64'(req_ready), 64'h0);
      @(negedge clk);
      rst_l = 1'b1;
      applyStimulus(4'b1111, ALL_DATA, 1'b1);
      #1;
      checkOutput("post-reset req_ready", 64'(req_ready), 64'h1);
      @(posedge clk);
      #1;
      checkOutput("post-reset out_src",  64'(out_src),  64'h0);
      checkOutput("post-reset out_data", 64'(out_data), 64'h0010);
      checkOutput("post-reset rr_ptr",   64'(rr_ptr_o), 64'h1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/rvdff_share_arb.md
Name: rvdff_share_arb

Overview:
- Round-robin arbiter and sequencer that shares one WIDTH-bit flop-based holding register (rvdff datapath) among NREQ requesters.
- Requesters offer data with valid/ready; the winner's data is captured into the holding register and presented downstream with valid/ready.
- Sits between multiple producers (e.g. CSR/debug writers) and a single consumer of a registered value.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 16, data width of each requester and of the holding register.

Ports:
- clk  input  1  clock.
- rst_l  input  1  asynchronous active-low reset.
- req_valid  input  NREQ  per-requester valid.
- req_data  input  NREQ*WIDTH  packed data; requester i occupies bits [i*WIDTH +: WIDTH].
- req_ready  output  NREQ  one-hot-or-zero grant/accept.
- out_valid  output  1  holding register contains data.
- out_data  output  WIDTH  holding register contents.
- out_src  output  $clog2(NREQ)  index of the requester that wrote out_data.
- out_ready  input  1  consumer accepts out_data.
- rr_ptr_o  output  $clog2(NREQ)  current round-robin priority pointer (debug).

Behaviour:
- Reset (rst_l low, async): out_valid=0, out_data=0, out_src=0, rr_ptr=0, lock state cleared. req_ready=0 while in reset.
- Holding-buffer FSM has two states, EMPTY and FULL.
  - can_accept = EMPTY, or (FULL and out_ready).
- Arbitration is combinational. When can_accept, grant the first requester with req_valid, searching from rr_ptr upward with wrap NREQ-1 -> 0.
  - req_ready is one-hot on the winner, else all zero.
  - req_ready never asserts without the matching req_valid.
- Transfer: req_valid[i] & req_ready[i].
  - Next edge: out_data <= req_data[i], out_src <= i, state FULL, rr_ptr <= (i+1) mod NREQ.
- Drain: out_valid & out_ready with no new transfer -> state EMPTY. out_data and out_src hold their last values.
- Simultaneous drain and transfer: the register is overwritten and the state stays FULL. This gives full throughput of 1 transfer/cycle.
- FULL and !out_ready: req_ready=0. out_data, out_src and out_valid are stable until out_ready is seen.
- Latency: accepted data appears on out_data exactly 1 cycle after the transfer edge.
- rr_ptr changes only on a transfer. With no valid requests it holds.
- Fairness: with all requesters continuously valid and out_ready=1, grants cycle 0,1,..,NREQ-1,0.
- Reset mid-operation: buffered data is discarded, out_valid drops immediately (async), and arbitration restarts from requester 0.

Optional Feature:
- Macro: RVDFF_SHARE_ARB_LOCK_EN.
- With it defined:
  - Adds input req_lock (NREQ).
  - If the winner of a transfer has req_lock[i]=1, a lock is set to i.
  - While locked, only requester i may be granted; others see req_ready=0 even if valid.
  - rr_ptr is not advanced while locked.
  - The lock releases on a transfer from i with req_lock[i]=0; rr_ptr then advances to i+1.
  - The lock also releases when req_valid[i] drops while can_accept.
  - Reset clears the lock.
- Without it: no req_lock port; pure round-robin.

Decomposition:
- Shared package (rvdff_share_pkg):
  - NREQ_MAX=8.
  - Function for $clog2-style index width.
  - Enum typedef for buffer state {EMPTY, FULL}.
- One natural sub-module: rr_pick.
  - Combinational round-robin priority picker.
  - Inputs: valid vector, pointer, enable.
  - Outputs: one-hot grant and encoded index.
- The holding register is a plain rvdff-style flop instance with enable, written in the top.

Test Plan:
- Reset: hold rst_l=0 with req_valid=4'b1111 -> req_ready=0, out_valid=0, out_data=0, rr_ptr_o=0; release rst_l -> first grant goes to requester 0.
- Single writer: req_valid=4'b0100, req_data[2]=16'hBEEF, out_ready=1 -> req_ready=4'b0100 that cycle; next cycle out_valid=1, out_data=16'hBEEF, out_src=2, rr_ptr_o=3.
- Round-robin fairness: all valid, data i=16'h0010+i, out_ready=1 for 8 cycles -> out_src sequence 0,1,2,3,0,1,2,3 with one output per cycle.
- Backpressure: FULL with out_data=16'h1234, out_ready=0 for 5 cycles while requesters 1,3 are valid -> req_ready=0 and out_data stays 16'h1234; raise out_ready -> simultaneous drain and refill from requester 1 (given rr_ptr=1), state stays FULL.
- Async reset mid-burst: drop rst_l between clock edges while FULL -> out_valid goes 0 before the next edge; after release, rr_ptr_o=0.
- LOCK (macro defined): requester 1 transfers 3 beats with req_lock=1 while 0,2,3 are valid -> only requester 1 granted; its 3rd beat with req_lock=0 releases, and the next grant goes to requester 2.
